// File: rtl/dcache_wb_ctrl_if.sv
// rtl/dcache_wb_ctrl_if.sv - CPU-side and line-wide memory-side handshake bundle for dcache_wb_ctrl
interface dcache_wb_ctrl_if #(
  parameter int WORDS = 4
);
  logic               cpu_req;
  logic               cpu_we;
  logic [31:0]        cpu_addr;
  logic [31:0]        cpu_wdata;
  logic [31:0]        cpu_rdata;
  logic               cpu_ready;
  logic               mem_req;
  logic               mem_we;
  logic [31:0]        mem_addr;
  logic [32*WORDS-1:0] mem_wdata;
  logic [32*WORDS-1:0] mem_rdata;
  logic               mem_ack;

  // slave: the cache itself; master: the CPU/memory environment around it
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wb_ctrl.sv
// rtl/dcache_wb_ctrl.sv - direct-mapped write-back/write-allocate data cache with miss FSM
// Optional hit/miss counters enabled by defining DCACHE_STATS_EN.
module dcache_wb_ctrl #(
  parameter int INDEX_W = 6,
  parameter int OFFS_W  = 2,
  parameter int TAG_W   = 32 - INDEX_W - OFFS_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  dcache_wb_ctrl_if.slave   bus,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int WORDS = 2 ** OFFS_W;
  localparam int SETS  = 2 ** INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, FILL} state_t;
  typedef logic [WORDS-1:0][31:0] line_t;

  state_t state, state_d;

  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic [OFFS_W-1:0]  offs_q;
  logic               we_q;
  logic [31:0]        wdata_q;

  logic [SETS-1:0]    valid;
  logic [SETS-1:0]    dirty;
  line_t              data_mem [SETS];
  logic [TAG_W-1:0]   tag_mem  [SETS];

  logic               ready_q, ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  line_t              mem_wdata_q, mem_wdata_d;

  line_t              line_rd;
  logic [TAG_W-1:0]   tag_rd;
  logic               hit;
  logic               accept;
  logic               mem_done;
  logic               store_hit;
  logic               fill_done;
  logic               unused_addr_bits;

  assign unused_addr_bits = &{1'b0, bus.cpu_addr[1:0]};

  // Arrays are addressed by the latched index, giving registered-index read behaviour
  assign line_rd   = data_mem[idx_q];
  assign tag_rd    = tag_mem[idx_q];
  assign hit       = valid[idx_q] && (tag_rd == tag_q);
  // The cycle that presents cpu_ready still sees the old cpu_req; it must not be re-accepted
  assign accept    = (state == IDLE) && bus.cpu_req && !ready_q;
  // Only an ack that answers an outstanding request counts
  assign mem_done  = bus.mem_ack && mem_req_q;
  assign store_hit = (state == LOOKUP) && hit && we_q;
  assign fill_done = (state == FILL) && mem_done;

  always_comb begin
    state_d     = state;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state)
      IDLE: begin
        if (accept) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          ready_d = 1'b1;
          if (!we_q) rdata_d = line_rd[offs_q];
          state_d = IDLE;
        end else if (valid[idx_q] && dirty[idx_q]) begin
          state_d     = WB;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {tag_rd, idx_q, {(OFFS_W + 2){1'b0}}};
          mem_wdata_d = line_rd;
        end else begin
          state_d    = FILL;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {tag_q, idx_q, {(OFFS_W + 2){1'b0}}};
        end
      end
      WB: begin
        if (mem_done) begin
          state_d   = FILL;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      FILL: begin
        if (mem_done) begin
          state_d   = LOOKUP;
          mem_req_d = 1'b0;
        end else begin
          // After a write-back the request is re-raised here following one idle cycle
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {tag_q, idx_q, {(OFFS_W + 2){1'b0}}};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tag_q       <= '0;
      idx_q       <= '0;
      offs_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      valid       <= '0;
      dirty       <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state       <= state_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (accept) begin
        tag_q   <= bus.cpu_addr[31 -: TAG_W];
        idx_q   <= bus.cpu_addr[OFFS_W + 2 +: INDEX_W];
        offs_q  <= bus.cpu_addr[2 +: OFFS_W];
        we_q    <= bus.cpu_we;
        wdata_q <= bus.cpu_wdata;
      end
      if (fill_done) begin
        valid[idx_q] <= 1'b1;
        dirty[idx_q] <= 1'b0;
      end
      if (store_hit) dirty[idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[idx_q] <= bus.mem_rdata;
      tag_mem[idx_q]  <= tag_q;
    end else if (store_hit) begin
      data_mem[idx_q][offs_q] <= wdata_q;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ready = ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic first_q;

  // first_q marks the initial LOOKUP of an access so the post-fill replay is not counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q  <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (accept) first_q <= 1'b1;
      else if (state == LOOKUP) first_q <= 1'b0;
      if ((state == LOOKUP) && first_q) begin
        if (hit) begin
          if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
        end else begin
          if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// tb/tb_dcache_wb_ctrl.sv - directed self-checking bench for dcache_wb_ctrl
module tb_dcache_wb_ctrl;
  logic        clk;
  logic        rst;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  int          total;
  int          bad;

  // memory responder state and request log
  int           ack_delay;
  int           cnt;
  bit           busy;
  logic         log_we [$];
  logic [31:0]  log_addr [$];
  logic [127:0] log_wd [$];

  dcache_wb_ctrl_if #(.WORDS(4)) bus ();

  dcache_wb_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // refill data: word i of line at address a is a + 0xA000_0000 + i
  function automatic logic [127:0] line_for(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = a + 32'hA000_0000 + 32'(i);
    return l;
  endfunction

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    busy = 0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0;
        bus.mem_ack = 1'b0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        if (!busy) begin
          busy = 1;
          cnt  = ack_delay;
          log_we.push_back(bus.mem_we);
          log_addr.push_back(bus.mem_addr);
          log_wd.push_back(bus.mem_wdata);
        end
        if (cnt == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = line_for(bus.mem_addr);
          busy = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic clear_log();
    log_we.delete();
    log_addr.delete();
    log_wd.delete();
  endtask

  // Called at a negedge; returns at a negedge with cpu_req low and the cache idle
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
    bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
    lat = 0;
    rdata = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.cpu_addr = ~addr; bus.cpu_wdata = 32'h0; bus.cpu_we = ~we;
      end
      if (bus.cpu_ready) break;
    end
    bus.cpu_req = 1'b0;
    if (!bus.cpu_ready) begin
      total++; bad++;
      $display("FAIL cpu_timeout addr=%h got no ready, need ready", addr);
    end else begin
      rdata = bus.cpu_rdata;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (bus.cpu_ready !== 1'b0) begin bad++; $display("FAIL rst_cpu_ready got=%b need=0", bus.cpu_ready); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b need=0", bus.mem_req); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b need=0", bus.mem_we); end
    total++; if (bus.cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_cpu_rdata got=%h need=0", bus.cpu_rdata); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h need=0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 128'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h need=0", bus.mem_wdata); end
    total++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin bad++; $display("FAIL rst_counters got=%0d/%0d need=0/0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_cold_load();
    logic [31:0] rd; int lat;
    clear_log();
    cpu_access(1'b0, 32'h0000_0100, 32'h0, rd, lat);
    total++; if (log_addr.size() != 1 || log_we[0] !== 1'b0 || log_addr[0] !== 32'h100) begin
      bad++; $display("FAIL cold_fill got=%0d reqs, need one read at 0x100", log_addr.size()); end
    total++; if (rd !== 32'hA000_0100) begin bad++; $display("FAIL cold_rdata got=%h need=a0000100", rd); end
    cpu_access(1'b0, 32'h0000_0100, 32'h0, rd, lat);
    total++; if (rd !== 32'hA000_0100 || lat != 2) begin bad++; $display("FAIL reload_hit got=%h lat=%0d need=a0000100 lat=2", rd, lat); end
    total++; if (log_addr.size() != 1) begin bad++; $display("FAIL reload_no_mem got=%0d reqs need=1", log_addr.size()); end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd; int lat;
    clear_log();
    cpu_access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, rd, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL store_lat got=%0d need=2", lat); end
    cpu_access(1'b0, 32'h0000_0104, 32'h0, rd, lat);
    total++; if (rd !== 32'hDEAD_BEEF || lat != 2) begin bad++; $display("FAIL store_readback got=%h lat=%0d need=deadbeef lat=2", rd, lat); end
    total++; if (log_addr.size() != 0) begin bad++; $display("FAIL store_no_mem got=%0d reqs need=0", log_addr.size()); end
  endtask

  task automatic test_writeback();
    logic [31:0] rd; int lat;
    clear_log();
    cpu_access(1'b0, 32'h0000_1100, 32'h0, rd, lat);
    total++; if (log_addr.size() != 2) begin bad++; $display("FAIL wb_req_count got=%0d need=2", log_addr.size()); end
    else begin
      total++; if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h100) begin
        bad++; $display("FAIL wb_addr got we=%b addr=%h need we=1 addr=100", log_we[0], log_addr[0]); end
      total++; if (log_wd[0] !== 128'hA000_0103_A000_0102_DEAD_BEEF_A000_0100) begin
        bad++; $display("FAIL wb_data got=%h need=a0000103a0000102deadbeefa0000100", log_wd[0]); end
      total++; if (log_we[1] !== 1'b0 || log_addr[1] !== 32'h1100) begin
        bad++; $display("FAIL wb_then_fill got we=%b addr=%h need we=0 addr=1100", log_we[1], log_addr[1]); end
    end
    total++; if (rd !== 32'hA000_1100) begin bad++; $display("FAIL wb_rdata got=%h need=a0001100", rd); end
  endtask

  task automatic test_stats();
    logic [31:0] eh, em;
`ifdef DCACHE_STATS_EN
    eh = 32'd3; em = 32'd2;
`else
    eh = 32'd0; em = 32'd0;
`endif
    total++; if (hit_cnt !== eh || miss_cnt !== em) begin
      bad++; $display("FAIL stats got hit=%0d miss=%0d need hit=%0d miss=%0d", hit_cnt, miss_cnt, eh, em); end
  endtask

  task automatic test_boundaries();
    logic [31:0] rd; int lat;
    cpu_access(1'b0, 32'h0000_110C, 32'h0, rd, lat);
    total++; if (rd !== 32'hA000_1103 || lat != 2) begin bad++; $display("FAIL msb_word got=%h lat=%0d need=a0001103 lat=2", rd, lat); end
    clear_log();
    cpu_access(1'b0, 32'h0000_0000, 32'h0, rd, lat);
    total++; if (log_addr.size() != 1 || log_addr[0] !== 32'h0 || rd !== 32'hA000_0000) begin
      bad++; $display("FAIL index0_tag0_miss got reqs=%0d rd=%h need reqs=1 rd=a0000000", log_addr.size(), rd); end
    clear_log();
    cpu_access(1'b0, 32'h0000_03F8, 32'h0, rd, lat);
    total++; if (log_addr.size() != 1 || log_addr[0] !== 32'h3F0 || rd !== 32'hA000_03F2) begin
      bad++; $display("FAIL index_last_fill got reqs=%0d rd=%h need reqs=1 rd=a00003f2", log_addr.size(), rd); end
    cpu_access(1'b0, 32'h0000_03FC, 32'h0, rd, lat);
    total++; if (rd !== 32'hA000_03F3 || lat != 2) begin bad++; $display("FAIL index_last_hit got=%h lat=%0d need=a00003f3 lat=2", rd, lat); end
  endtask

  task automatic test_ack_stall();
    logic [31:0] rd; int lat; int errs; int seen;
    clear_log();
    ack_delay = 20;
    errs = 0; seen = 0;
    fork
      cpu_access(1'b0, 32'h0000_2100, 32'h0, rd, lat);
      begin
        for (int i = 0; i < 10 && !seen; i++) begin
          @(negedge clk);
          if (bus.mem_req) seen = 1;
        end
        for (int i = 0; i < 18 && seen; i++) begin
          @(negedge clk);
          if (!(bus.mem_req === 1'b1 && bus.mem_addr === 32'h2100 && bus.mem_we === 1'b0 && bus.cpu_ready === 1'b0)) errs++;
        end
      end
    join
    ack_delay = 0;
    total++; if (seen == 0 || errs != 0) begin bad++; $display("FAIL stall_stable got seen=%0d bad_cycles=%0d need seen=1 bad_cycles=0", seen, errs); end
    total++; if (rd !== 32'hA000_2100 || lat <= 20) begin bad++; $display("FAIL stall_result got=%h lat=%0d need=a0002100 lat>20", rd, lat); end
    total++; if (log_addr.size() != 1) begin bad++; $display("FAIL stall_no_wb got=%0d reqs need=1", log_addr.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd0, rd1; int n0, n1;
    n0 = 0; n1 = 0; rd0 = '0; rd1 = '0;
    bus.cpu_we = 1'b0; bus.cpu_addr = 32'h2100; bus.cpu_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin n0 = i; rd0 = bus.cpu_rdata; break; end
    end
    bus.cpu_addr = 32'h2104;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin n1 = i; rd1 = bus.cpu_rdata; break; end
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    total++; if (n0 != 2 || rd0 !== 32'hA000_2100) begin bad++; $display("FAIL b2b_first got lat=%0d rd=%h need lat=2 rd=a0002100", n0, rd0); end
    total++; if (n1 != 3 || rd1 !== 32'hA000_2101) begin bad++; $display("FAIL b2b_second got gap=%0d rd=%h need gap=3 rd=a0002101", n1, rd1); end
  endtask

  task automatic test_reset_fill();
    logic [31:0] rd; int lat; int seen;
    ack_delay = 1000;
    seen = 0;
    bus.cpu_we = 1'b0; bus.cpu_addr = 32'h3100; bus.cpu_req = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req) seen = 1;
    end
    total++; if (seen == 0 || bus.mem_addr !== 32'h3100 || bus.mem_we !== 1'b0) begin
      bad++; $display("FAIL rf_fill_start got seen=%0d addr=%h need seen=1 addr=3100", seen, bus.mem_addr); end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rf_req_drop got=%b need=0", bus.mem_req); end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0 || bus.cpu_ready !== 1'b0) begin
      bad++; $display("FAIL rf_held got req=%b ready=%b need 0/0", bus.mem_req, bus.cpu_ready); end
    rst = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    clear_log();
    cpu_access(1'b0, 32'h0000_0100, 32'h0, rd, lat);
    total++; if (log_addr.size() != 1 || log_we[0] !== 1'b0 || log_addr[0] !== 32'h100 || rd !== 32'hA000_0100) begin
      bad++; $display("FAIL rf_later_miss got reqs=%0d rd=%h need one fill at 100 rd=a0000100", log_addr.size(), rd); end
    clear_log();
    cpu_access(1'b0, 32'h0000_03FC, 32'h0, rd, lat);
    total++; if (log_addr.size() != 1 || log_addr[0] !== 32'h3F0) begin
      bad++; $display("FAIL rf_all_invalid got reqs=%0d need one fill at 3f0", log_addr.size()); end
  endtask

  initial begin
    total = 0; bad = 0; ack_delay = 0;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_cold_load();
    test_store_hit();
    test_writeback();
    test_stats();
    test_boundaries();
    test_ack_stall();
    test_back_to_back();
    test_reset_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
